// File: rtl/matmul_pkg.sv
// matmul_pkg -- shared definitions for the matmul lane engine.
//   * default parameter constants
//   * engine state enum
//   * saturate(): clamps a wide signed value to a signed out_w range
package matmul_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_OUT_W  = 32;
  localparam int DEF_LANES  = 4;
  localparam int DEF_DIM_W  = 11;

  // Working width for saturate(); accumulators are sign-extended into it.
  localparam int SAT_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    WRITE,
    FIN
  } state_t;

  // Clamp v to [-2^(out_w-1), 2^(out_w-1)-1]; caller truncates to out_w bits.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] hi, lo;
    hi = (SAT_W'(1) << (out_w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane -- one output column of the engine: signed multiply, clear-load
// on the first product of a tile, accumulate afterwards, narrow on output.
//   clk, rst_n  : clock, synchronous active-low reset (clears accumulator)
//   en          : a/b carry a valid product term this cycle
//   first       : load instead of add (first term of a tile)
//   a, b        : signed DATA_W operands
//   result      : accumulator narrowed to OUT_W
// Build option: MATMUL_LANE_SAT_EN -> saturate to signed OUT_W range,
// otherwise keep the low OUT_W bits (two's-complement wrap).
module mac_lane
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     first,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [OUT_W-1:0]  result
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q;

  // Widen before multiplying so the full signed product is kept.
  assign prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (!rst_n)     acc_q <= '0;
    else if (en)    acc_q <= first ? prod_ext : acc_q + prod_ext;
  end

`ifdef MATMUL_LANE_SAT_EN
  assign result = OUT_W'(saturate(SAT_W'(acc_q), OUT_W));
`else
  assign result = OUT_W'(acc_q);
`endif

endmodule

// File: rtl/matmul_lane_engine.sv
// matmul_lane_engine -- C[MxN] = A[MxK] * B[KxN], LANES columns per tile.
// Tiles are walked row-major (row r, column base col0); each tile streams K
// A elements and K B row-slices, drains the last read, then writes one
// masked C row-slice.
//   clk, rst_n              : clock, synchronous active-low reset
//   start/busy/done/err     : request pulse, activity, completion/error pulses
//   m_val/k_val/n_val       : dimensions, sampled when start is accepted
//   a_rd_en/addr/data       : A element read, data one cycle after enable
//   b_rd_en/addr/data       : B row-slice read, lane j = B[k][col0+j]
//   c_wr_valid/ready/addr/data/mask : C row-slice write, held until ready
// Build option: MATMUL_LANE_SAT_EN (output saturation in mac_lane).
module matmul_lane_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int LANES  = DEF_LANES,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic [DIM_W-1:0]          m_val,
  input  logic [DIM_W-1:0]          k_val,
  input  logic [DIM_W-1:0]          n_val,
  output logic                      a_rd_en,
  output logic [2*DIM_W-1:0]        a_rd_addr,
  input  logic [DATA_W-1:0]         a_rd_data,
  output logic                      b_rd_en,
  output logic [2*DIM_W-1:0]        b_rd_addr,
  input  logic [LANES*DATA_W-1:0]   b_rd_data,
  output logic                      c_wr_valid,
  input  logic                      c_wr_ready,
  output logic [2*DIM_W-1:0]        c_wr_addr,
  output logic [LANES*OUT_W-1:0]    c_wr_data,
  output logic [LANES-1:0]          c_wr_mask
);

  localparam int AW = 2*DIM_W;
  localparam logic [DIM_W-1:0] MAX_DIM = {1'b1, {(DIM_W-1){1'b0}}};

  state_t             state, state_nx;
  logic [DIM_W-1:0]   m_q, k_q, n_q;
  logic [DIM_W-1:0]   r_q, col0_q, kk_q;
  logic               err_q;
  logic               data_vld, data_first;   // read data in flight this cycle
  logic               dims_ok, last_k, last_col, last_row;
  logic [DIM_W:0]     col_next;
  logic [LANES-1:0]   lane_mask;

  assign dims_ok  = (m_val != '0) && (m_val <= MAX_DIM) &&
                    (k_val != '0) && (k_val <= MAX_DIM) &&
                    (n_val != '0) && (n_val <= MAX_DIM);
  assign last_k   = (kk_q == k_q - DIM_W'(1));
  assign col_next = {1'b0, col0_q} + (DIM_W+1)'(LANES);
  assign last_col = (col_next >= {1'b0, n_q});
  assign last_row = (r_q == m_q - DIM_W'(1));

  // ---- next state and outputs ----
  always_comb begin
    state_nx   = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    err        = 1'b0;
    a_rd_en    = 1'b0;
    b_rd_en    = 1'b0;
    a_rd_addr  = '0;
    b_rd_addr  = '0;
    c_wr_valid = 1'b0;
    c_wr_addr  = '0;
    case (state)
      IDLE:  if (start) state_nx = dims_ok ? LOAD : FIN;
      LOAD: begin
        a_rd_en   = 1'b1;
        b_rd_en   = 1'b1;
        a_rd_addr = AW'(r_q) * AW'(k_q) + AW'(kk_q);
        b_rd_addr = AW'(kk_q) * AW'(n_q) + AW'(col0_q);
        if (last_k) state_nx = DRAIN;
      end
      DRAIN: state_nx = WRITE;
      WRITE: begin
        c_wr_valid = 1'b1;
        c_wr_addr  = AW'(r_q) * AW'(n_q) + AW'(col0_q);
        if (c_wr_ready) state_nx = (last_col && last_row) ? FIN : LOAD;
      end
      FIN: begin
        done     = 1'b1;
        err      = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- state, dimensions, tile indices ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      m_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      r_q        <= '0;
      col0_q     <= '0;
      kk_q       <= '0;
      err_q      <= 1'b0;
      data_vld   <= 1'b0;
      data_first <= 1'b0;
    end else begin
      state      <= state_nx;
      data_vld   <= (state == LOAD);
      data_first <= (state == LOAD) && (kk_q == '0);
      case (state)
        IDLE: if (start) begin
          m_q    <= m_val;
          k_q    <= k_val;
          n_q    <= n_val;
          r_q    <= '0;
          col0_q <= '0;
          kk_q   <= '0;
          err_q  <= !dims_ok;
        end
        LOAD: kk_q <= last_k ? '0 : kk_q + DIM_W'(1);
        WRITE: if (c_wr_ready) begin
          if (last_col) begin
            col0_q <= '0;
            r_q    <= r_q + DIM_W'(1);
          end else begin
            col0_q <= col0_q + DIM_W'(LANES);
          end
        end
        default: ;
      endcase
    end
  end

  // ---- lanes ----
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic signed [OUT_W-1:0] res;

    mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (data_vld),
      .first  (data_first),
      .a      (a_rd_data),
      .b      (b_rd_data[j*DATA_W +: DATA_W]),
      .result (res)
    );

    assign lane_mask[j] = ({1'b0, col0_q} + (DIM_W+1)'(j)) < {1'b0, n_q};
    assign c_wr_data[j*OUT_W +: OUT_W] = (c_wr_valid && lane_mask[j]) ? res : '0;
  end

  assign c_wr_mask = c_wr_valid ? lane_mask : '0;

endmodule

// File: tb/tb_matmul_lane_engine.sv
// Directed bench for matmul_lane_engine (DATA_W=16, OUT_W=16, LANES=4).
// Honors MATMUL_LANE_SAT_EN for the overflow vector's expected value.
module tb_matmul_lane_engine;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 16;
  localparam int LANES  = 4;
  localparam int DIM_W  = 11;
  localparam int AW     = 2*DIM_W;

`ifdef MATMUL_LANE_SAT_EN
  localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
  localparam logic [15:0] OVF_EXP = 16'h0004;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n, start, busy, done, err;
  logic [DIM_W-1:0]        m_val, k_val, n_val;
  logic                    a_rd_en, b_rd_en;
  logic [AW-1:0]           a_rd_addr, b_rd_addr;
  logic [DATA_W-1:0]       a_rd_data;
  logic [LANES*DATA_W-1:0] b_rd_data;
  logic                    c_wr_valid, c_wr_ready;
  logic [AW-1:0]           c_wr_addr;
  logic [LANES*OUT_W-1:0]  c_wr_data;
  logic [LANES-1:0]        c_wr_mask;

  matmul_lane_engine #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .LANES(LANES), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .m_val(m_val), .k_val(k_val), .n_val(n_val),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .c_wr_valid(c_wr_valid), .c_wr_ready(c_wr_ready), .c_wr_addr(c_wr_addr),
    .c_wr_data(c_wr_data), .c_wr_mask(c_wr_mask)
  );

  always #5 clk = ~clk;

  // ---- memories and monitors ----
  logic [DATA_W-1:0] a_mem [256];
  logic [DATA_W-1:0] b_mem [256];
  int cyc = 0, rd_a_cnt = 0, rd_b_cnt = 0, done_cnt = 0, cyc_start = 0;
  logic [AW-1:0]          wq_addr [$];
  logic [LANES*OUT_W-1:0] wq_data [$];
  logic [LANES-1:0]       wq_mask [$];

  function automatic logic [DATA_W-1:0] rd_mem_a(input int idx);
    return (idx < 256) ? a_mem[idx] : '0;
  endfunction
  function automatic logic [DATA_W-1:0] rd_mem_b(input int idx);
    return (idx < 256) ? b_mem[idx] : '0;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_rd_en) begin
      a_rd_data <= rd_mem_a(int'(a_rd_addr));
      rd_a_cnt  <= rd_a_cnt + 1;
    end
    if (b_rd_en) begin
      for (int j = 0; j < LANES; j++)
        b_rd_data[j*DATA_W +: DATA_W] <= rd_mem_b(int'(b_rd_addr) + j);
      rd_b_cnt <= rd_b_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (rst_n && c_wr_valid && c_wr_ready) begin
      wq_addr.push_back(c_wr_addr);
      wq_data.push_back(c_wr_data);
      wq_mask.push_back(c_wr_mask);
    end
  end

  // ---- checking ----
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input int p, input logic [AW-1:0] addr,
                        input logic [3:0] mask, input logic [63:0] data);
    logic [AW-1:0] oa = '1;
    logic [3:0]    om = '1;
    logic [63:0]   od = '1;
    if (p < wq_addr.size()) begin
      oa = wq_addr[p];
      om = wq_mask[p];
      od = wq_data[p];
    end
    chk($sformatf("wr%0d_addr", p), 64'(oa), 64'(addr));
    chk($sformatf("wr%0d_mask", p), 64'(om), 64'(mask));
    chk($sformatf("wr%0d_data", p), od, data);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
  endtask

  task automatic load_2x2();
    clear_mem();
    a_mem[0] = 16'd1; a_mem[1] = 16'd2; a_mem[2] = 16'd3; a_mem[3] = 16'd4;
    b_mem[0] = 16'd5; b_mem[1] = 16'd6; b_mem[2] = 16'd7; b_mem[3] = 16'd8;
  endtask

  task automatic start_op(input int m, input int k, input int n);
    @(negedge clk);
    m_val = DIM_W'(m);
    k_val = DIM_W'(k);
    n_val = DIM_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc_start = cyc;
  endtask

  // Latency counts the start cycle as 0; the done cycle index is returned.
  task automatic wait_done(output int lat, output logic e, output logic b);
    lat = -1;
    e   = 1'b0;
    b   = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (done) begin
        lat = cyc - cyc_start + 1;
        e   = err;
        b   = busy;
        break;
      end
      @(negedge clk);
    end
  endtask

  int   lat, wb, ra, rb, dc;
  logic e, b;
  logic [63:0] a2x2_w0, a2x2_w1;

  initial begin
    a2x2_w0 = {16'd0, 16'd0, 16'd22, 16'd19};
    a2x2_w1 = {16'd0, 16'd0, 16'd50, 16'd43};
    rst_n = 1'b0; start = 1'b0; c_wr_ready = 1'b1;
    m_val = '0; k_val = '0; n_val = '0;
    clear_mem();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_err",   64'(err), 64'd0);
    chk("rst_rd",    64'({a_rd_en, b_rd_en}), 64'd0);
    chk("rst_valid", 64'(c_wr_valid), 64'd0);
    chk("rst_data",  64'(c_wr_data), 64'd0);
    chk("rst_mask",  64'(c_wr_mask), 64'd0);
    rst_n = 1'b1;

    // 2x2x2
    load_2x2();
    wb = wq_addr.size(); ra = rd_a_cnt; rb = rd_b_cnt;
    start_op(2, 2, 2);
    chk("a_busy", 64'(busy), 64'd1);
    wait_done(lat, e, b);
    chk("a_lat", 64'(lat), 64'd9);
    chk("a_err", 64'(e), 64'd0);
    chk("a_busy_fin", 64'(b), 64'd1);
    @(negedge clk);
    chk("a_wr_cnt", 64'(wq_addr.size() - wb), 64'd2);
    chk("a_rd_cnt", 64'(rd_a_cnt - ra), 64'd4);
    chk("b_rd_cnt", 64'(rd_b_cnt - rb), 64'd4);
    chk_wr(wb,     22'd0, 4'b0011, a2x2_w0);
    chk_wr(wb + 1, 22'd2, 4'b0011, a2x2_w1);

    // 1x3x5, all ones: partial second tile
    clear_mem();
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = 16'd1;
      b_mem[i] = 16'd1;
    end
    wb = wq_addr.size();
    start_op(1, 3, 5);
    wait_done(lat, e, b);
    chk("b_lat", 64'(lat), 64'd11);
    @(negedge clk);
    chk("b_wr_cnt", 64'(wq_addr.size() - wb), 64'd2);
    chk_wr(wb,     22'd0, 4'b1111, {4{16'd3}});
    chk_wr(wb + 1, 22'd4, 4'b0001, {48'd0, 16'd3});

    // rejects: zero and oversize dimension
    wb = wq_addr.size(); ra = rd_a_cnt;
    start_op(2, 2, 0);
    chk("z_done", 64'(done), 64'd1);
    chk("z_err",  64'(err), 64'd1);
    wait_done(lat, e, b);
    chk("z_lat", 64'(lat), 64'd1);
    start_op(1025, 1, 1);
    wait_done(lat, e, b);
    chk("o_lat", 64'(lat), 64'd1);
    chk("o_err", 64'(e), 64'd1);
    @(negedge clk);
    chk("z_rd", 64'(rd_a_cnt - ra), 64'd0);
    chk("z_wr", 64'(wq_addr.size() - wb), 64'd0);

    // largest legal dimension is accepted
    start_op(1024, 1, 1);
    wait_done(lat, e, b);
    chk("max_lat", 64'(lat), 64'd3073);
    chk("max_err", 64'(e), 64'd0);

    // signed products
    clear_mem();
    a_mem[0] = -16'sd3; a_mem[1] = 16'sd2;
    b_mem[0] = 16'sd5;  b_mem[1] = -16'sd7;
    wb = wq_addr.size();
    start_op(1, 2, 1);
    wait_done(lat, e, b);
    chk("neg_lat", 64'(lat), 64'd5);
    @(negedge clk);
    chk_wr(wb, 22'd0, 4'b0001, {48'd0, 16'hFFE3});

    // overflow of the OUT_W range
    clear_mem();
    for (int i = 0; i < 32; i++) begin
      a_mem[i] = 16'h7FFF;
      b_mem[i] = 16'h7FFF;
    end
    wb = wq_addr.size();
    start_op(1, 4, 4);
    wait_done(lat, e, b);
    chk("ovf_lat", 64'(lat), 64'd7);
    @(negedge clk);
    chk_wr(wb, 22'd0, 4'b1111, {4{OVF_EXP}});

    // write stall of 5 cycles on the first write
    load_2x2();
    wb = wq_addr.size();
    c_wr_ready = 1'b0;
    start_op(2, 2, 2);
    for (int i = 0; i < 50 && !c_wr_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("st_valid", 64'(c_wr_valid), 64'd1);
      chk("st_addr",  64'(c_wr_addr), 64'd0);
      chk("st_mask",  64'(c_wr_mask), 64'b0011);
      chk("st_data",  c_wr_data, a2x2_w0);
      chk("st_rd",    64'({a_rd_en, b_rd_en}), 64'd0);
      @(negedge clk);
    end
    c_wr_ready = 1'b1;
    wait_done(lat, e, b);
    chk("st_lat", 64'(lat), 64'd14);
    @(negedge clk);
    chk("st_wr_cnt", 64'(wq_addr.size() - wb), 64'd2);
    chk_wr(wb,     22'd0, 4'b0011, a2x2_w0);
    chk_wr(wb + 1, 22'd2, 4'b0011, a2x2_w1);

    // reset during LOAD of the second tile, then a clean rerun
    start_op(2, 2, 2);
    for (int i = 0; i < 50 && !c_wr_valid; i++) @(negedge clk);
    @(negedge clk);
    chk("mr_rd_en",   64'(a_rd_en), 64'd1);
    chk("mr_rd_addr", 64'(a_rd_addr), 64'd2);
    dc = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_rd",   64'(a_rd_en), 64'd0);
    repeat (12) @(negedge clk);
    chk("mr_no_done", 64'(done_cnt - dc), 64'd0);
    wb = wq_addr.size();
    start_op(2, 2, 2);
    wait_done(lat, e, b);
    chk("mr_lat", 64'(lat), 64'd9);
    @(negedge clk);
    chk("mr_wr_cnt", 64'(wq_addr.size() - wb), 64'd2);
    chk_wr(wb,     22'd0, 4'b0011, a2x2_w0);
    chk_wr(wb + 1, 22'd2, 4'b0011, a2x2_w1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_lane_engine.md
MATMUL_LANE_ENGINE -- requirements
Module: matmul_lane_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed operand width of A and B elements.
REQ-002 SHALL have parameter ACC_W, default 40, signed accumulator width per lane.
REQ-003 SHALL have parameter OUT_W, default 32, signed width of each C element written.
REQ-004 SHALL have parameter LANES, default 4, number of C columns computed in parallel per tile.
REQ-005 SHALL have parameter DIM_W, default 11, width of the dimension inputs; the maximum legal dimension is 2^(DIM_W-1).
REQ-006 SHALL have ports `clk` in 1 (sole clock) and `rst_n` in 1 (synchronous, active-low reset), stated as the fixed clocking/reset scheme.
REQ-007 SHALL have ports `start` in 1 (request pulse), `busy` out 1, `done` out 1 (one-cycle completion pulse) and `err` out 1 (one-cycle error pulse, coincident with `done`).
REQ-008 SHALL have ports `m_val`, `k_val`, `n_val`, each in DIM_W, as the M, K, N dimensions, sampled only when `start` is accepted.
REQ-009 SHALL have A read port: `a_rd_en` out 1, `a_rd_addr` out 2*DIM_W, `a_rd_data` in DATA_W.
REQ-010 SHALL have B read port: `b_rd_en` out 1, `b_rd_addr` out 2*DIM_W, `b_rd_data` in LANES*DATA_W, where lane j is B[k][col0+j].
REQ-011 SHALL have C write port: `c_wr_valid` out 1, `c_wr_ready` in 1, `c_wr_addr` out 2*DIM_W, `c_wr_data` out LANES*OUT_W and `c_wr_mask` out LANES.

Function
REQ-012 SHALL treat read data as valid exactly one cycle after the corresponding `*_rd_en` assertion.
REQ-013 SHALL accept `start` only in IDLE; `start` SHALL be ignored while `busy`=1.
REQ-014 SHALL reject `start` if any dimension is 0 or exceeds 2^(DIM_W-1): no reads and no writes, then `done`=1 and `err`=1 in the following cycle.
REQ-015 SHALL implement states IDLE, LOAD, DRAIN, WRITE and FIN, with transitions IDLE->LOAD on valid start, LOAD->DRAIN after K read cycles, DRAIN->WRITE, WRITE->LOAD (next tile) or WRITE->FIN on the last handshake, and FIN->IDLE.
REQ-016 SHALL visit tiles (row r, column base col0 = t*LANES) row-major, with T = M*ceil(N/LANES) tiles in total.
REQ-017 In LOAD cycle k, SHALL assert both read enables with a_rd_addr = r*K + k and b_rd_addr = k*N + col0.
REQ-018 On the first data cycle of a tile, SHALL load each lane accumulator with the product, and SHALL add the product on later cycles; the full signed product SHALL be sign-extended to ACC_W.
REQ-019 SHALL hold `c_wr_valid`, `c_wr_addr` (= r*N + col0), `c_wr_data` and `c_wr_mask` stable in WRITE until `c_wr_ready`=1.
REQ-020 SHALL set `c_wr_mask` bit j only when col0+j < N; unmasked lanes SHALL have defined values, masked lanes SHALL be driven as 0.
REQ-021 With `c_wr_ready` held at 1, SHALL take exactly T*(K+2)+1 cycles from accepted `start` to the `done` pulse.
REQ-022 SHALL keep `busy`=1 from the cycle after start acceptance through FIN inclusive.
REQ-023 SHALL issue no reads while in WRITE, so a stalled `c_wr_ready` SHALL stall the engine without losing data.

Reset
REQ-024 When `rst_n`=0 at a clock edge, SHALL clear the state to IDLE, all outputs to 0 and all accumulators and indices to 0.
REQ-025 SHALL discard any in-flight tile on reset mid-operation; no `done` pulse SHALL follow that reset.

Configuration
REQ-026 With macro MATMUL_LANE_SAT_EN defined, SHALL clamp each accumulator to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1] on output.
REQ-027 Without MATMUL_LANE_SAT_EN, SHALL output the low OUT_W bits of each accumulator (two's-complement wrap).

Structure
REQ-028 SHALL place the state enum typedef, default parameter constants and the saturate function in shared package matmul_pkg.
REQ-029 SHALL instantiate LANES copies of sub-module mac_lane, each providing multiply, clear-load, accumulate and output narrowing.

Verification
REQ-030 Bench SHALL cover: M=K=N=2, LANES=4, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> one write per row, C=[[19,22],[43,50]], mask=4'b0011, done at cycle 2*(2+2)+1=9.
REQ-031 Bench SHALL cover: M=1, K=3, N=5, all A and B elements 1 -> two writes at addr 0 (mask 1111, data 3) and addr 4 (mask 0001, data 3).
REQ-032 Bench SHALL cover: n_val=0 -> no rd_en or c_wr_valid, done=err=1 one cycle after start.
REQ-033 Bench SHALL cover: c_wr_ready held low for 5 cycles during the first write -> outputs stable throughout, no reads, result matches the unstalled run.
REQ-034 Bench SHALL cover: DATA_W=16, OUT_W=16, K=4, all A and B elements 32767 -> 0x7FFF per lane with MATMUL_LANE_SAT_EN, low 16 bits of 4*32767^2 (0x0004) without it.
REQ-035 Bench SHALL cover: rst_n=0 during LOAD of the second tile, then a new start -> clean run, no stale done pulse, correct results.
